// File: rtl/dht11_pkg.sv
// Shared DHT11 definitions: scheduler states, response codes, default timing
// constants and the 8-bit wrap-around checksum helper.
package dht11_pkg;

  localparam int unsigned MIN_GAP_CYC_DEF  = 100_000_000;
  localparam int unsigned START_TO_CYC_DEF = 50_000;
  localparam int unsigned BUSY_TO_CYC_DEF  = 5_000_000;
  localparam int unsigned MAX_RETRY_DEF    = 3;
  localparam int unsigned CNT_W_DEF        = 27;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GAP_WAIT,
    S_START,
    S_WAIT_HOLD,
    S_BUSY,
    S_CHECK,
    S_FAIL,
    S_RESP
  } sched_state_e;

  typedef logic [1:0] resp_status_t;

  localparam resp_status_t ST_FRESH   = 2'b00;
  localparam resp_status_t ST_CACHED  = 2'b01;
  localparam resp_status_t ST_CSUM    = 2'b10;
  localparam resp_status_t ST_TIMEOUT = 2'b11;

  typedef struct packed {
    logic [7:0] hum_int;
    logic [7:0] hum_frac;
    logic [7:0] temp_int;
    logic [7:0] temp_frac;
  } dht11_sample_t;

  function automatic logic [7:0] dht11_sum8(input dht11_sample_t s);
    return s.hum_int + s.hum_frac + s.temp_int + s.temp_frac;
  endfunction

endpackage

// File: rtl/dht11_checksum.sv
// Combinational DHT11 checksum: mod-256 sum of the four data bytes compared
// against the transmitted checksum byte.
module dht11_checksum
  import dht11_pkg::*;
(
  input  dht11_sample_t sample_i,
  input  logic [7:0]    checksum_i,
  output logic          match_o
);

  logic [7:0] sum;

  assign sum     = dht11_sum8(sample_i);
  assign match_o = (sum == checksum_i);

endmodule

// File: rtl/dht11_read_scheduler.sv
// Host-side DHT11 read scheduler: serialises requests, enforces the minimum
// spacing between physical reads, validates and retries, and caches good data.
module dht11_read_scheduler
  import dht11_pkg::*;
#(
  parameter int unsigned MIN_GAP_CYC  = MIN_GAP_CYC_DEF,
  parameter int unsigned START_TO_CYC = START_TO_CYC_DEF,
  parameter int unsigned BUSY_TO_CYC  = BUSY_TO_CYC_DEF,
  parameter int unsigned MAX_RETRY    = MAX_RETRY_DEF,
  parameter int unsigned CNT_W        = CNT_W_DEF
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       req_valid_i,
  output logic       req_ready_o,
  input  logic       req_force_i,
  output logic       resp_valid_o,
  output logic [1:0] resp_status_o,
  output logic [7:0] resp_hum_int_o,
  output logic [7:0] resp_hum_frac_o,
  output logic [7:0] resp_temp_int_o,
  output logic [7:0] resp_temp_frac_o,
  output logic       dec_enable_o,
  output logic       dec_reset_o,
  input  logic       dec_hold_i,
  input  logic       dec_error_i,
  input  logic       dec_done_i,
  input  logic [7:0] dec_hum_int_i,
  input  logic [7:0] dec_hum_frac_i,
  input  logic [7:0] dec_temp_int_i,
  input  logic [7:0] dec_temp_frac_i,
  input  logic [7:0] dec_checksum_i
);

  localparam int unsigned RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  localparam logic [CNT_W-1:0] MIN_GAP  = CNT_W'(MIN_GAP_CYC);
  localparam logic [CNT_W-1:0] START_TO = CNT_W'(START_TO_CYC);
  localparam logic [CNT_W-1:0] BUSY_TO  = CNT_W'(BUSY_TO_CYC);
  localparam logic [RW-1:0]    MAX_R    = RW'(MAX_RETRY);

  sched_state_e  state_q;
  logic [CNT_W-1:0] gap_q, gap_d;
  logic [CNT_W-1:0] to_q;
  logic [RW-1:0] retry_q;
  logic          err_seen_q;
  logic          cache_valid_q;
  dht11_sample_t cache_q;
  resp_status_t  cause_q;
  logic          req_ready_q;
  logic          resp_valid_q;
  resp_status_t  resp_status_q;
  dht11_sample_t resp_data_q;
  logic          dec_reset_q;

  dht11_sample_t dec_sample;
  logic          csum_match;
  logic          gap_full;
  logic          gap_clr;
  logic          accept;
  logic          cache_hit;

  assign dec_sample = '{hum_int:   dec_hum_int_i,
                        hum_frac:  dec_hum_frac_i,
                        temp_int:  dec_temp_int_i,
                        temp_frac: dec_temp_frac_i};

  dht11_checksum u_checksum (
    .sample_i   (dec_sample),
    .checksum_i (dec_checksum_i),
    .match_o    (csum_match)
  );

  assign gap_full  = (gap_q == MIN_GAP);
  // The gap restarts on the same edge that raises dec_reset, so it counts
  // cycles since the most recent decoder start.
  assign gap_clr   = (state_q == S_GAP_WAIT) && gap_full;
  assign accept    = req_valid_i && req_ready_q;
  assign cache_hit = cache_valid_q && !req_force_i && !gap_full;

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    gap_d = gap_q;
    if (gap_clr) begin
      gap_d = '0;
    end else if (!gap_full) begin
      gap_d = gap_q + CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      gap_q <= MIN_GAP;
    end else begin
      gap_q <= gap_d;
    end
  end

  // NOTE: the cache registers are reset explicitly; a stale cached sample must
  // never be reported after reset, even though cache_valid also guards it.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q       <= S_IDLE;
      to_q          <= '0;
      retry_q       <= '0;
      err_seen_q    <= 1'b0;
      cache_valid_q <= 1'b0;
      cache_q       <= '0;
      cause_q       <= ST_FRESH;
      req_ready_q   <= 1'b0;
      resp_valid_q  <= 1'b0;
      resp_status_q <= ST_FRESH;
      resp_data_q   <= '0;
      dec_reset_q   <= 1'b0;
    end else begin
      resp_valid_q <= 1'b0;
      dec_reset_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          req_ready_q <= 1'b1;
          if (accept) begin
            req_ready_q <= 1'b0;
            if (cache_hit) begin
              resp_valid_q  <= 1'b1;
              resp_status_q <= ST_CACHED;
              resp_data_q   <= cache_q;
              state_q       <= S_RESP;
            end else begin
              retry_q <= '0;
              state_q <= S_GAP_WAIT;
            end
          end
        end
        S_GAP_WAIT: begin
          if (gap_full) begin
            dec_reset_q <= 1'b1;
            state_q     <= S_START;
          end
        end
        S_START: begin
          to_q       <= '0;
          err_seen_q <= 1'b0;
          state_q    <= S_WAIT_HOLD;
        end
        S_WAIT_HOLD: begin
          // dec_done still reflects the previous read here; only hold matters.
          if (dec_hold_i) begin
            to_q    <= '0;
            state_q <= S_BUSY;
          end else if (to_q >= START_TO) begin
            cause_q <= ST_TIMEOUT;
            state_q <= S_FAIL;
          end else begin
            to_q <= to_q + CNT_W'(1);
          end
        end
        S_BUSY: begin
          if (dec_error_i) begin
            err_seen_q <= 1'b1;
          end
          if (!dec_hold_i && dec_done_i) begin
            state_q <= S_CHECK;
          end else if (to_q >= BUSY_TO) begin
            cause_q <= ST_TIMEOUT;
            state_q <= S_FAIL;
          end else begin
            to_q <= to_q + CNT_W'(1);
          end
        end
        S_CHECK: begin
          // After an error the decoder reports zeroed bytes that would pass.
          if (err_seen_q || !csum_match) begin
            cause_q <= ST_CSUM;
            state_q <= S_FAIL;
          end else begin
            cache_q       <= dec_sample;
            cache_valid_q <= 1'b1;
            resp_valid_q  <= 1'b1;
            resp_status_q <= ST_FRESH;
            resp_data_q   <= dec_sample;
            state_q       <= S_RESP;
          end
        end
        S_FAIL: begin
          if (retry_q < MAX_R) begin
            retry_q <= retry_q + RW'(1);
            state_q <= S_GAP_WAIT;
          end else begin
            resp_valid_q  <= 1'b1;
            resp_status_q <= cause_q;
            resp_data_q   <= cache_valid_q ? cache_q : '0;
            state_q       <= S_RESP;
          end
        end
        S_RESP: begin
          req_ready_q <= 1'b1;
          state_q     <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready_o      = req_ready_q;
  assign resp_valid_o     = resp_valid_q;
  assign resp_status_o    = resp_status_q;
  assign resp_hum_int_o   = resp_data_q.hum_int;
  assign resp_hum_frac_o  = resp_data_q.hum_frac;
  assign resp_temp_int_o  = resp_data_q.temp_int;
  assign resp_temp_frac_o = resp_data_q.temp_frac;
  assign dec_enable_o     = 1'b1;
  assign dec_reset_o      = dec_reset_q;

endmodule

// File: tb/tb_dht11_read_scheduler.sv
// Scoreboard bench for dht11_read_scheduler with a scripted DHT11 decoder model.
module tb_dht11_read_scheduler;
  import dht11_pkg::*;

  localparam int MIN_GAP   = 1000;
  localparam int START_TO  = 50;
  localparam int BUSY_TO   = 2000;
  localparam int MAX_RETRY = 3;

  localparam logic [1:0] K_OK     = 2'd0;
  localparam logic [1:0] K_NOHOLD = 2'd1;
  localparam logic [1:0] K_ERR    = 2'd2;

  typedef struct packed {
    logic [1:0]  kind;
    logic [31:0] data;
    logic [7:0]  csum;
  } attempt_t;

  typedef struct packed {
    logic [1:0]  status;
    logic [31:0] data;
  } resp_t;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_force = 1'b0;
  logic       req_ready, resp_valid, dec_enable, dec_reset;
  logic [1:0] resp_status;
  logic [7:0] resp_hum_int, resp_hum_frac, resp_temp_int, resp_temp_frac;
  logic       dec_hold, dec_error, dec_done;
  logic [7:0] dec_hum_int, dec_hum_frac, dec_temp_int, dec_temp_frac, dec_checksum;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int resp_cnt = 0;
  int resp_cyc = 0;
  int pulse_w = 0;
  logic prev_dec_reset = 1'b0;
  logic model_busy = 1'b0;

  attempt_t plan_q[$];
  resp_t    exp_q[$];
  int       pulse_cyc_q[$];

  dht11_read_scheduler #(
    .MIN_GAP_CYC  (MIN_GAP),
    .START_TO_CYC (START_TO),
    .BUSY_TO_CYC  (BUSY_TO),
    .MAX_RETRY    (MAX_RETRY),
    .CNT_W        (27)
  ) dut (
    .clock_i          (clock),
    .reset_i          (reset),
    .req_valid_i      (req_valid),
    .req_ready_o      (req_ready),
    .req_force_i      (req_force),
    .resp_valid_o     (resp_valid),
    .resp_status_o    (resp_status),
    .resp_hum_int_o   (resp_hum_int),
    .resp_hum_frac_o  (resp_hum_frac),
    .resp_temp_int_o  (resp_temp_int),
    .resp_temp_frac_o (resp_temp_frac),
    .dec_enable_o     (dec_enable),
    .dec_reset_o      (dec_reset),
    .dec_hold_i       (dec_hold),
    .dec_error_i      (dec_error),
    .dec_done_i       (dec_done),
    .dec_hum_int_i    (dec_hum_int),
    .dec_hum_frac_i   (dec_hum_frac),
    .dec_temp_int_i   (dec_temp_int),
    .dec_temp_frac_i  (dec_temp_frac),
    .dec_checksum_i   (dec_checksum)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Decoder-start monitor: records each pulse and checks it is one cycle wide.
  always @(negedge clock) begin
    if (dec_reset && !prev_dec_reset) pulse_cyc_q.push_back(cyc);
    if (dec_reset) pulse_w++;
    else if (prev_dec_reset) begin
      check("dec_reset_width", pulse_w, 1);
      pulse_w = 0;
    end
    prev_dec_reset = dec_reset;
  end

  // Response monitor: pops the scoreboard whenever the DUT strobes a response.
  always @(negedge clock) begin
    if (!reset && resp_valid) begin
      resp_t e;
      resp_cnt++;
      resp_cyc = cyc;
      check("resp_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("resp_status", resp_status, e.status);
        check("resp_data", {resp_hum_int, resp_hum_frac, resp_temp_int, resp_temp_frac}, e.data);
      end
    end
  end

  // Decoder model: each start pulse consumes one scripted attempt. dec_done is
  // left high between reads to mimic a stale data-ready flag.
  initial begin
    attempt_t a;
    dec_hold = 0; dec_error = 0; dec_done = 0;
    {dec_hum_int, dec_hum_frac, dec_temp_int, dec_temp_frac, dec_checksum} = '0;
    forever begin
      @(negedge clock);
      if (dec_reset) begin
        model_busy = 1'b1;
        check("plan_available", plan_q.size() != 0, 1);
        a = (plan_q.size() != 0) ? plan_q.pop_front() : '{kind: K_NOHOLD, data: '0, csum: '0};
        if (a.kind != K_NOHOLD) begin
          repeat (3) @(negedge clock);
          dec_hold = 1'b1;
          dec_done = 1'b0;
          repeat (20) @(negedge clock);
          if (a.kind == K_ERR) begin
            dec_error = 1'b1;
            @(negedge clock);
            dec_error = 1'b0;
            repeat (5) @(negedge clock);
            {dec_hum_int, dec_hum_frac, dec_temp_int, dec_temp_frac, dec_checksum} = '0;
          end else begin
            {dec_hum_int, dec_hum_frac, dec_temp_int, dec_temp_frac} = a.data;
            dec_checksum = a.csum;
          end
          dec_hold = 1'b0;
          dec_done = 1'b1;
        end
        model_busy = 1'b0;
      end
    end
  end

  task automatic plan(input logic [1:0] kind, input logic [31:0] data, input logic [7:0] cs);
    plan_q.push_back('{kind: kind, data: data, csum: cs});
  endtask

  task automatic expect_resp(input logic [1:0] st, input logic [31:0] data);
    exp_q.push_back('{status: st, data: data});
  endtask

  task automatic send_req(input logic frc, output int acc_cyc);
    int n = 0;
    @(negedge clock);
    while (!req_ready && n < 8000) begin
      @(negedge clock);
      n++;
    end
    if (n >= 8000) check("req_ready_wait", req_ready, 1);
    req_valid = 1'b1;
    req_force = frc;
    acc_cyc   = cyc;
    @(negedge clock);
    req_valid = 1'b0;
    req_force = 1'b0;
    check("req_ready_after_accept", req_ready, 0);
  endtask

  task automatic wait_resp(input int r0, input int budget);
    int n = 0;
    while (resp_cnt == r0 && n < budget) begin
      @(negedge clock);
      n++;
    end
    check("resp_arrived", resp_cnt, r0 + 1);
  endtask

  task automatic check_spacing(input int p0, input int np, input string name, input bit exact);
    check({name, "_pulses"}, pulse_cyc_q.size() - p0, np);
    for (int i = p0 + 1; i < pulse_cyc_q.size(); i++) begin
      if (exact) check({name, "_gap"}, pulse_cyc_q[i] - pulse_cyc_q[i-1], MIN_GAP + 1);
      else       check({name, "_gap_min"}, (pulse_cyc_q[i] - pulse_cyc_q[i-1]) >= MIN_GAP, 1);
    end
  endtask

  initial begin
    int acc, r0, p0, n;

    // Reset values
    repeat (3) @(negedge clock);
    check("rst_req_ready", req_ready, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp", {resp_status, resp_hum_int, resp_hum_frac, resp_temp_int, resp_temp_frac}, 0);
    check("rst_dec_enable", dec_enable, 1);
    check("rst_dec_reset", dec_reset, 0);
    reset = 1'b0;
    @(negedge clock);
    check("ready_after_reset", req_ready, 1);

    // 1: first fresh read, no gap delay after reset
    p0 = pulse_cyc_q.size(); r0 = resp_cnt;
    plan(K_OK, {8'd45, 8'd0, 8'd23, 8'd5}, 8'd73);
    expect_resp(ST_FRESH, {8'd45, 8'd0, 8'd23, 8'd5});
    send_req(1'b0, acc);
    wait_resp(r0, 500);
    check("t1_pulses", pulse_cyc_q.size() - p0, 1);
    if (pulse_cyc_q.size() > p0) check("t1_start_latency", pulse_cyc_q[p0] - acc, 2);

    // 2: cached answer shortly after, one cycle after accept
    repeat (100) @(negedge clock);
    p0 = pulse_cyc_q.size(); r0 = resp_cnt;
    expect_resp(ST_CACHED, {8'd45, 8'd0, 8'd23, 8'd5});
    send_req(1'b0, acc);
    wait_resp(r0, 10);
    check("t2_latency", resp_cyc - acc, 1);
    check("t2_pulses", pulse_cyc_q.size() - p0, 0);

    // 3: forced read waits out the gap; pulse lands MIN_GAP+1 cycles later
    p0 = pulse_cyc_q.size() - 1; r0 = resp_cnt;
    plan(K_OK, {8'd50, 8'd1, 8'd24, 8'd0}, 8'd75);
    expect_resp(ST_FRESH, {8'd50, 8'd1, 8'd24, 8'd0});
    send_req(1'b1, acc);
    wait_resp(r0, 3000);
    check_spacing(p0, 2, "t3", 1'b1);

    // 4: checksum wrong on every attempt -> 4 starts, status 10, cached bytes
    p0 = pulse_cyc_q.size(); r0 = resp_cnt;
    for (int i = 0; i < 4; i++) plan(K_OK, {8'd45, 8'd0, 8'd23, 8'd5}, 8'd74);
    expect_resp(ST_CSUM, {8'd50, 8'd1, 8'd24, 8'd0});
    send_req(1'b1, acc);
    wait_resp(r0, 6000);
    check_spacing(p0, 4, "t4", 1'b0);
    r0 = resp_cnt;
    expect_resp(ST_CACHED, {8'd50, 8'd1, 8'd24, 8'd0});
    send_req(1'b0, acc);
    wait_resp(r0, 10);

    // 5: decoder error then zeroed done must fail; retry succeeds
    p0 = pulse_cyc_q.size(); r0 = resp_cnt;
    plan(K_ERR, '0, 8'd0);
    plan(K_OK, {8'd12, 8'd34, 8'd20, 8'd9}, 8'd75);
    expect_resp(ST_FRESH, {8'd12, 8'd34, 8'd20, 8'd9});
    send_req(1'b1, acc);
    wait_resp(r0, 4000);
    check("t5_pulses", pulse_cyc_q.size() - p0, 2);
    r0 = resp_cnt;
    expect_resp(ST_CACHED, {8'd12, 8'd34, 8'd20, 8'd9});
    send_req(1'b0, acc);
    wait_resp(r0, 10);

    // 6: decoder never raises hold -> 4 start timeouts, status 11
    p0 = pulse_cyc_q.size(); r0 = resp_cnt;
    for (int i = 0; i < 4; i++) plan(K_NOHOLD, '0, 8'd0);
    expect_resp(ST_TIMEOUT, {8'd12, 8'd34, 8'd20, 8'd9});
    send_req(1'b1, acc);
    wait_resp(r0, 6000);
    check_spacing(p0, 4, "t6", 1'b0);

    // 7: all-zero data with checksum 0 is legal
    r0 = resp_cnt;
    plan(K_OK, '0, 8'd0);
    expect_resp(ST_FRESH, '0);
    send_req(1'b1, acc);
    wait_resp(r0, 3000);

    // 8: reset while BUSY -> IDLE, no response, ready next cycle
    r0 = resp_cnt;
    plan(K_OK, {8'd45, 8'd0, 8'd23, 8'd5}, 8'd73);
    send_req(1'b1, acc);
    n = 0;
    while (!dec_hold && n < 3000) begin
      @(negedge clock);
      n++;
    end
    check("t8_hold_seen", dec_hold, 1);
    repeat (5) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("t8_rst_ready", req_ready, 0);
    check("t8_rst_dec_reset", dec_reset, 0);
    check("t8_rst_resp", {resp_valid, resp_status, resp_hum_int, resp_hum_frac, resp_temp_int, resp_temp_frac}, 0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("t8_ready_after_reset", req_ready, 1);
    n = 0;
    while (model_busy && n < 200) begin
      @(negedge clock);
      n++;
    end
    repeat (20) @(negedge clock);
    check("t8_no_resp", resp_cnt, r0);

    // 9: cache cleared and gap saturated by reset; wrap-around checksum
    p0 = pulse_cyc_q.size(); r0 = resp_cnt;
    plan(K_OK, {8'd1, 8'd2, 8'd3, 8'd250}, 8'd0);
    expect_resp(ST_FRESH, {8'd1, 8'd2, 8'd3, 8'd250});
    send_req(1'b0, acc);
    wait_resp(r0, 500);
    check("t9_pulses", pulse_cyc_q.size() - p0, 1);
    if (pulse_cyc_q.size() > p0) check("t9_start_latency", pulse_cyc_q[p0] - acc, 2);

    repeat (5) @(negedge clock);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
